// File: rtl/uart_rx_if.sv
// Signal bundle between the serial line, the 8N1 receiver and the word consumer.
// The slave modport is the receiver's view; master is the line/consumer side.
interface uart_rx_if;
    logic        rx;
    logic [31:0] sensor_data;
    logic        data_valid;
    logic        frame_error;
    logic [1:0]  byte_count;

    modport master (
        output rx,
        input  sensor_data,
        input  data_valid,
        input  frame_error,
        input  byte_count
    );

    modport slave (
        input  rx,
        output sensor_data,
        output data_valid,
        output frame_error,
        output byte_count
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver that packs four consecutive bytes (first byte in [7:0]) into a
// 32-bit word, with stop-bit framing check and an inter-byte timeout.
module uart_rx #(
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned CLOCK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input logic      clk,
    input logic      reset_n,
    uart_rx_if.slave bus
);

    localparam int unsigned ClksPerBit  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CntW        = $clog2(ClksPerBit);
    localparam int unsigned TimeoutClks = TIMEOUT_BITS * ClksPerBit;
    localparam int unsigned ToW         = $clog2(TimeoutClks + 1);

    localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(TimeoutClks - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       word_q, word_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ToW-1:0]    to_q, to_d;
    logic              rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        asm_d     = asm_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        bcnt_d    = bcnt_q;
        to_d      = '0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end else if (bcnt_q != 2'd0) begin
                    // Partial word is dropped after too long a gap between bytes.
                    if (to_q == ToLast) begin
                        bcnt_d = 2'd0;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d                     = StIdle;
                        asm_d[{bcnt_q, 3'b000} +: 8] = shift_q;
                        if (bcnt_q == 2'd3) begin
                            word_d  = {shift_q, asm_q[23:0]};
                            valid_d = 1'b1;
                            bcnt_d  = 2'd0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        state_d = StWaitIdle;
                        ferr_d  = 1'b1;
                        bcnt_d  = 2'd0;
                    end
                end
            end
            StWaitIdle: begin
                // A held-low line (break) must not be re-read as start bits.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            asm_q     <= 32'd0;
            word_q    <= 32'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            bcnt_q    <= 2'd0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], bus.rx};
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            asm_q     <= asm_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            bcnt_q    <= bcnt_d;
            to_q      <= to_d;
        end
    end

    assign bus.sensor_data = word_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.byte_count  = bcnt_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a byte/word-level model predicts words, framing errors
// and byte counts; a per-cycle monitor checks the DUT outputs against it.
module tb_uart_rx;

    localparam int Bit     = 1600;  // 16 clocks of 100 time units
    localparam int BitFast = 1568;  // 2% short bit period
    localparam int BitSlow = 1632;  // 2% long bit period

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    uart_rx_if bus ();

    uart_rx #(
        .BAUD_RATE   (10),
        .CLOCK_FREQ  (160),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_word = 32'd0;
    logic [7:0]  part[4];
    int          model_cnt = 0;
    int          fe_expected = 0;
    int          fe_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle monitor: every data_valid must match a predicted word, every
    // frame_error a predicted bad stop bit, and sensor_data must hold otherwise.
    always @(negedge clk) begin
        if (bus.data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_valid=1 data %h expected none at %0t",
                         bus.sensor_data, $time);
            end else begin
                model_word = exp_q.pop_front();
            end
        end
        if (bus.frame_error) begin
            if (fe_expected == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_error: got 1 expected 0 at %0t", $time);
            end else begin
                fe_expected--;
                fe_seen++;
            end
        end
        check("sensor_data", bus.sensor_data, model_word);
        check("dv_fe_exclusive", 32'(bus.data_valid & bus.frame_error), 32'h0);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int period);
        if (stop_ok) begin
            if (model_cnt == 3) begin
                exp_q.push_back({b, part[2], part[1], part[0]});
                model_cnt = 0;
            end else begin
                part[model_cnt] = b;
                model_cnt++;
            end
        end else begin
            fe_expected++;
            model_cnt = 0;
        end
        bus.rx = 1'b0;
        #(period);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(period);
        end
        bus.rx = stop_ok;
        #(period);
        if (period == Bit) check("byte_count", 32'(bus.byte_count), 32'(model_cnt));
    endtask

    task automatic send_word(input logic [31:0] w, input int period);
        @(posedge clk);
        #20;
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, period);
        #(2 * Bit);
        check("word_drained", 32'(exp_q.size()), 32'd0);
        check("byte_count_word_end", 32'(bus.byte_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx = 1'b1;
        #230;
        check("reset_sensor_data", bus.sensor_data, 32'd0);
        check("reset_data_valid", 32'(bus.data_valid), 32'd0);
        check("reset_frame_error", 32'(bus.frame_error), 32'd0);
        check("reset_byte_count", 32'(bus.byte_count), 32'd0);
        reset_n = 1'b1;
        #(2 * Bit);

        // Back-to-back word
        send_word(32'hDEADBEEF, Bit);
        check("pin_deadbeef", bus.sensor_data, 32'hDEADBEEF);

        // Glitch rejection with one byte pending
        @(posedge clk);
        #20;
        send_byte(8'h77, 1'b1, Bit);
        @(posedge clk);
        #20;
        bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        #20;
        bus.rx = 1'b1;
        #(Bit);
        check("glitch_byte_count", 32'(bus.byte_count), 32'd1);
        send_byte(8'h88, 1'b1, Bit);
        send_byte(8'h99, 1'b1, Bit);
        send_byte(8'h66, 1'b1, Bit);
        #(2 * Bit);
        check("pin_after_glitch", bus.sensor_data, 32'h66998877);

        // Framing error followed by a held-low line
        @(posedge clk);
        #20;
        send_byte(8'h11, 1'b1, Bit);
        send_byte(8'h22, 1'b0, Bit);
        repeat (40) @(posedge clk);
        #10;
        check("break_byte_count", 32'(bus.byte_count), 32'd0);
        bus.rx = 1'b1;
        #(2 * Bit);
        check("frame_error_pulses", 32'(fe_seen), 32'd1);
        send_word(32'h04030201, Bit);
        check("pin_04030201", bus.sensor_data, 32'h04030201);

        // Inter-byte timeout
        @(posedge clk);
        #20;
        send_byte(8'hAA, 1'b1, Bit);
        send_byte(8'hBB, 1'b1, Bit);
        repeat (300) @(posedge clk);
        #10;
        check("timeout_not_early", 32'(bus.byte_count), 32'd2);
        repeat (21) @(posedge clk);
        #10;
        check("timeout_cleared", 32'(bus.byte_count), 32'd0);
        model_cnt = 0;
        send_word(32'h40302010, Bit);
        check("pin_40302010", bus.sensor_data, 32'h40302010);

        // Reset during data bits of the second byte
        @(posedge clk);
        #20;
        send_byte(8'h12, 1'b1, Bit);
        bus.rx = 1'b0;
        #(Bit);
        bus.rx = 1'b1;
        #(Bit);
        bus.rx = 1'b0;
        #(Bit);
        model_word = 32'd0;
        model_cnt  = 0;
        exp_q.delete();
        reset_n = 1'b0;
        #10;
        check("midreset_sensor_data", bus.sensor_data, 32'd0);
        check("midreset_data_valid", 32'(bus.data_valid), 32'd0);
        check("midreset_frame_error", 32'(bus.frame_error), 32'd0);
        check("midreset_byte_count", 32'(bus.byte_count), 32'd0);
        bus.rx = 1'b1;
        #300;
        reset_n = 1'b1;
        #(2 * Bit);
        send_word(32'hCAFEF00D, Bit);
        check("pin_cafef00d", bus.sensor_data, 32'hCAFEF00D);

        // Baud skew, fast then slow
        send_word(32'h5A5AA5A5, BitFast);
        check("pin_skew_fast", bus.sensor_data, 32'h5A5AA5A5);
        send_word(32'h5A5AA5A5, BitSlow);
        check("pin_skew_slow", bus.sensor_data, 32'h5A5AA5A5);

        check("frame_errors_outstanding", 32'(fe_expected), 32'd0);
        check("words_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the sensor link. It deserialises 8N1 UART frames on `rx`, LSB first, and assembles four consecutive bytes into a 32-bit `sensor_data` word. The first byte received lands in bits [7:0]. The block sits at the host/collector end of the link, opposite the sensor-side transmitter. It is fully synchronous to `clk` and presents each completed word with a one-cycle valid strobe.

## Interface
- `BAUD_RATE`, 9600: line bit rate in bits/s.
- `CLOCK_FREQ`, 100_000_000: `clk` frequency in Hz. `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE`, integer division, must be ≥ 4.
- `TIMEOUT_BITS`, 20: idle bit periods after which a partially assembled word is discarded.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `sensor_data`  out  32  last complete word; holds its value until the next word completes.
- `data_valid`  out  1  one-cycle pulse when `sensor_data` updates.
- `frame_error`  out  1  one-cycle pulse when a stop bit is sampled low.
- `byte_count`  out  2  bytes captured in the current partial word (0–3).

## Operation
- `rx` passes through a 2-flop synchroniser, initialised high. All logic uses the synchronised value `rx_s`.
- One bit-period counter, `ceil(log2(CLKS_PER_BIT))` bits wide. It reloads to 0 on every state transition.
- IDLE:
  - `rx_s` == 0 → START.
- START: wait until counter == `CLKS_PER_BIT/2 - 1`, then sample.
  - Sample 0 → DATA, bit index = 0.
  - Sample 1 (glitch) → IDLE, no error.
- DATA: wait until counter == `CLKS_PER_BIT - 1`, then sample `rx_s` into shift bit [index].
  - After index 7 → STOP.
- STOP: wait until counter == `CLKS_PER_BIT - 1`, then sample.
  - Sample 1: write the byte into lane `byte_count` of the assembly register.
    - If `byte_count` == 3: copy the assembled word to `sensor_data`, pulse `data_valid`, set `byte_count` to 0.
    - Otherwise increment `byte_count`.
    - Next state IDLE.
  - Sample 0: pulse `frame_error`, discard the byte and the partial word (`byte_count` ← 0), then → WAIT_IDLE.
- WAIT_IDLE:
  - Stay while `rx_s` == 0 (break or stuck line).
  - `rx_s` == 1 → IDLE. A break must never be taken as repeated start bits.
- Inter-byte timeout: a counter runs in IDLE while `byte_count` != 0.
  - Reaching `TIMEOUT_BITS * CLKS_PER_BIT` cycles sets `byte_count` to 0. No pulse is generated.
  - Any start-bit detection clears this counter.
- `data_valid` and `frame_error` are never asserted in the same cycle.

## Timing
- Reset values:
  - `sensor_data` = 0, `data_valid` = 0, `frame_error` = 0, `byte_count` = 0.
  - State = IDLE, synchroniser flops = 1, assembly register = 0.
- Reset asserted mid-frame aborts immediately. After release, the receiver re-arms in IDLE. A frame already in flight is resynchronised only at the next falling edge seen in IDLE.
- Start detection: 2 cycles of synchroniser latency after the `rx` falling edge, plus 1 cycle to enter START.
- Bit samples fall at mid-bit, nominally `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` cycles after START entry (k = 1..9).
- `data_valid` and `frame_error` are registered. Each asserts the cycle after the stop-bit sample and lasts exactly one cycle.
- `sensor_data` changes in the same cycle `data_valid` is high.
- Back-to-back frames with zero idle between the stop bit and the next start bit must be received. STOP returns to IDLE before the next falling edge at the line.
- Baud tolerance: ±2% cumulative error over a frame must be received correctly.

## Test plan
- Bench parameters: `CLOCK_FREQ` = 160, `BAUD_RATE` = 10, so `CLKS_PER_BIT` = 16.
- Back-to-back word: send bytes 0xEF, 0xBE, 0xAD, 0xDE → `sensor_data` = 0xDEADBEEF with a single-cycle `data_valid`. `byte_count` steps 1, 2, 3, 0. `frame_error` stays 0.
- Glitch rejection: pull `rx` low for 4 cycles in IDLE → no state advance past START, no pulses, `byte_count` unchanged.
- Framing error: send 0x11, then a frame 0x22 with stop bit = 0, then hold `rx` low for 40 cycles → `frame_error` pulses once, `byte_count` = 0. No start is decoded until `rx` returns high. A following 4-byte word 0x01, 0x02, 0x03, 0x04 yields 0x04030201.
- Timeout: send 0xAA, 0xBB, then idle 20×16 + 1 cycles → `byte_count` returns to 0. The next four bytes 0x10, 0x20, 0x30, 0x40 yield 0x40302010.
- Reset mid-frame: assert `reset_n` = 0 during the data bits of byte 2 → all outputs read 0 at once. After release, a clean word 0xCAFEF00D is received correctly.
- Baud skew: transmit 0x5A5AA5A5 with a 2% fast bit period, then with a 2% slow bit period → both received exactly.
